redundancy_compactor: RTL and testbench
=======================================

// Module: redundancy_compactor
// PURPOSE
//  Streaming successor of the redundancy controller. Accepts one lowered-IFM column per beat, tagged with its weight
//  coordinates. Flags each element that duplicates an element of the previously accepted column, then emits the
//  column with duplicates removed, plus a redundancy mask and distance. Sits between the lowering unit and the PE-array
//  feeder.
//  Adds: valid/ready handshake, 2-stage pipeline, runtime mode, value checking, channel/row awareness, statistics.
// PARAMETERS
//  WORD_WIDTH  8   bits per lifm element
//  DIST_WIDTH  7   width of row distance dr
//  C_SIZE      8   elements per column beat (power of 2, >=2)
//  K_WIDTH     4   width of kernel coordinates kx/ky
//  CH_WIDTH    8   width of input-channel id
//  CNT_WIDTH   $clog2(C_SIZE)+1   width of out_cnt
// PORTS
//  clk          in   1            clock, posedge
//  reset        in   1            synchronous, active-high
//  cfg_st_log2  in   3            log2(stride); stride restricted to power of 2
//  cfg_mode     in   2            0=bypass, 1=geometry-only, 2/3=geometry+value check
//  stat_clr     in   1            clears stat_red/stat_miss next cycle
//  in_valid     in   1            input beat valid
//  in_ready     out  1            input beat accepted when in_valid&in_ready
//  in_first     in   1            beat starts a new tile: history discarded
//  in_ch        in   CH_WIDTH     channel of weight
//  in_ky/in_kx  in   K_WIDTH      kernel row/col of weight
//  in_lifm      in   C_SIZE*WORD_WIDTH  column, element c at [c*WORD_WIDTH +: WORD_WIDTH]
//  out_valid    out  1            output beat valid
//  out_ready    in   1            downstream accepts
//  out_lifm     out  C_SIZE*WORD_WIDTH  non-redundant elements packed from c=0 in ascending order, rest zero
//  out_cnt      out  CNT_WIDTH    number of packed elements, 0..C_SIZE
//  out_rmask    out  C_SIZE       bit c=1: element c equals prev-column element c-out_dr
//  out_dr       out  DIST_WIDTH   distance used; 0 when no reuse
//  stat_red     out  32           saturating count of redundant elements
//  stat_miss    out  32           saturating count of geometry hits rejected by value check
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, all other outputs 0, history invalid, counters 0. Reset mid-stream drops in-flight beats.
//  - Pipeline: S1 registers beat + redundancy mask; S2 registers packed result. Latency 2 cycles accept->out_valid.
//    Stage advances iff it is empty or the next stage advances. in_ready = !S1_full | S2 advances (combinational
//    from out_ready). No bubbles at full throughput. out_* held stable while out_valid & !out_ready.
//  - History (prev ch/ky/kx/lifm) updated on every accepted beat. History invalid after reset or on in_first beat.
//  - Distance, computed on accept vs history: d = in_kx - prev_kx (K_WIDTH+1 signed).
//    geo_ok = hist_valid & !in_first & ch==prev_ch & ky==prev_ky & d>0 & d[st_log2-1:0]==0 & (d>>st_log2) < C_SIZE.
//    dr = geo_ok ? d>>st_log2 : 0.
//  - Element c is redundant iff mode!=0 & geo_ok & c>=dr, AND (mode==1 | in_lifm[c]==prev_lifm[c-dr]).
//  - Value check: mode>=2 & geometry hit & value differs -> not redundant, counted in stat_miss.
//  - Mode 0: rmask=0, cnt=C_SIZE, out_lifm=in_lifm, dr=0.
//  - Packing: stable compaction by prefix count of ~rmask. All-redundant -> cnt=0, out_lifm=0 (beat still emitted).
//  - Counters: incremented by popcount when a beat moves S1->S2; saturate at 2^32-1. stat_clr has priority over the
//    same-cycle increment.
//  - cfg_* changes are sampled per beat at accept. Software changes them only when the pipe is idle.
// STRUCTURE
//  - Shared package (redundancy_pkg): WORD_WIDTH/DIST_WIDTH defaults, mode encodings, lifm element/field index helpers.
//  - Sub-module rc_distance_calc: combinational geo_ok/dr from ch/ky/kx pairs + st_log2. Shared with the mapping-table
//    generator.
//  - Packing network and counters inline.
// TESTING
//  1 mode=1, st_log2=0, beats ch0 ky0 kx0 lifm{0..7}, then kx1 lifm{1..8}
//    -> 2nd out: dr=1, rmask=8'hFE, cnt=1, out_lifm[0]=8.
//  2 mode=2, same but 2nd beat element 3 corrupted -> rmask=8'hF6, cnt=2, stat_miss=1.
//  3 st_log2=1, kx0 then kx1 -> geo_ok=0, cnt=8; then kx2 -> dr=1; ky change or in_first -> dr=0, rmask=0.
//  4 Backpressure: 6 back-to-back beats, out_ready toggling 1010..
//    -> no loss/duplication, outputs stable while stalled, in_ready drops only when both stages are full.
//  5 mode=0 -> out_lifm==in_lifm, cnt=8. kx jump giving dr>=C_SIZE -> no redundancy.
//  6 Reset asserted with both stages full -> next cycle out_valid=0, counters 0, first post-reset beat has dr=0.

Source files
------------

// File: rtl/redundancy_pkg.sv
// redundancy_pkg: shared defaults, mode encodings and lifm index helpers for the redundancy datapath.
package redundancy_pkg;
  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_DIST_WIDTH = 7;
  localparam int DEF_C_SIZE = 8;
  localparam int DEF_K_WIDTH = 4;
  localparam int DEF_CH_WIDTH = 8;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GEO    = 2'd1,
    MODE_VAL    = 2'd2,
    MODE_VAL_X  = 2'd3
  } mode_e;
  function automatic int elem_lo(input int c, input int w);
    return c * w;
  endfunction
  function automatic int src_idx(input int c, input int dr, input int n);
    return (c - dr) & (n - 1);
  endfunction
endpackage

// File: rtl/rc_distance_calc.sv
// rc_distance_calc: geometric reuse test and row distance between a weight and the previous one.
module rc_distance_calc import redundancy_pkg::*; #(
  parameter int K_WIDTH = DEF_K_WIDTH,
  parameter int CH_WIDTH = DEF_CH_WIDTH,
  parameter int DIST_WIDTH = DEF_DIST_WIDTH,
  parameter int C_SIZE = DEF_C_SIZE
) (
  input  logic                  hist_valid,
  input  logic                  first,
  input  logic [CH_WIDTH-1:0]   ch,
  input  logic [CH_WIDTH-1:0]   prev_ch,
  input  logic [K_WIDTH-1:0]    ky,
  input  logic [K_WIDTH-1:0]    prev_ky,
  input  logic [K_WIDTH-1:0]    kx,
  input  logic [K_WIDTH-1:0]    prev_kx,
  input  logic [2:0]            st_log2,
  output logic                  geo_ok,
  output logic [DIST_WIDTH-1:0] dr
);
  logic [K_WIDTH:0] d, q;
  // d is treated as signed: positive means non-zero with a clear top bit
  always_comb begin
    d = {1'b0, kx} - {1'b0, prev_kx};
    q = d >> st_log2;
    geo_ok = hist_valid && !first && ch == prev_ch && ky == prev_ky && !d[K_WIDTH] && d != '0
             && (q << st_log2) == d && int'(q) < C_SIZE;
    dr = geo_ok ? DIST_WIDTH'(q) : '0;
  end
endmodule

// File: rtl/redundancy_compactor.sv
// redundancy_compactor: 2-stage stream that masks and squeezes out elements repeated from the previous column.
module redundancy_compactor import redundancy_pkg::*; #(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DIST_WIDTH = DEF_DIST_WIDTH,
  parameter int C_SIZE = DEF_C_SIZE,
  parameter int K_WIDTH = DEF_K_WIDTH,
  parameter int CH_WIDTH = DEF_CH_WIDTH,
  parameter int CNT_WIDTH = $clog2(C_SIZE) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   cfg_st_log2,
  input  logic [1:0]                   cfg_mode,
  input  logic                         stat_clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic [CH_WIDTH-1:0]          in_ch,
  input  logic [K_WIDTH-1:0]           in_ky,
  input  logic [K_WIDTH-1:0]           in_kx,
  input  logic [C_SIZE*WORD_WIDTH-1:0] in_lifm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [C_SIZE*WORD_WIDTH-1:0] out_lifm,
  output logic [CNT_WIDTH-1:0]         out_cnt,
  output logic [C_SIZE-1:0]            out_rmask,
  output logic [DIST_WIDTH-1:0]        out_dr,
  output logic [31:0]                  stat_red,
  output logic [31:0]                  stat_miss
);
  logic hist_valid, geo_ok, s1_full, s1_adv, s2_adv, accept;
  logic [CH_WIDTH-1:0] prev_ch;
  logic [K_WIDTH-1:0] prev_ky, prev_kx;
  logic [C_SIZE*WORD_WIDTH-1:0] prev_lifm, s1_lifm, packed_lifm;
  logic [DIST_WIDTH-1:0] geo_dr, s1_dr;
  logic [C_SIZE-1:0] eq, hit, red, miss, s1_rmask, s1_miss;
  logic [CNT_WIDTH-1:0] packed_cnt;
  logic [32:0] red_sum, miss_sum;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_full || s2_adv;
  assign in_ready = s1_adv;
  assign accept = in_valid && in_ready;
  rc_distance_calc #(
    .K_WIDTH(K_WIDTH), .CH_WIDTH(CH_WIDTH), .DIST_WIDTH(DIST_WIDTH), .C_SIZE(C_SIZE)
  ) u_dist (
    .hist_valid(hist_valid), .first(in_first), .ch(in_ch), .prev_ch(prev_ch), .ky(in_ky),
    .prev_ky(prev_ky), .kx(in_kx), .prev_kx(prev_kx), .st_log2(cfg_st_log2), .geo_ok(geo_ok), .dr(geo_dr)
  );
  always_comb begin
    eq = '0;
    hit = '0;
    for (int c = 0; c < C_SIZE; c++) begin
      eq[c] = in_lifm[elem_lo(c, WORD_WIDTH) +: WORD_WIDTH]
              == prev_lifm[elem_lo(src_idx(c, int'(geo_dr), C_SIZE), WORD_WIDTH) +: WORD_WIDTH];
      hit[c] = cfg_mode != MODE_BYPASS && geo_ok && c >= int'(geo_dr);
    end
    red = hit & (cfg_mode[1] ? eq : '1);
    miss = cfg_mode[1] ? hit & ~eq : '0;
  end
  // stable compaction: survivors land at their prefix rank
  always_comb begin : pack
    int n;
    n = 0;
    packed_lifm = '0;
    for (int c = 0; c < C_SIZE; c++) begin
      if (!s1_rmask[c]) begin
        packed_lifm[elem_lo(n, WORD_WIDTH) +: WORD_WIDTH] = s1_lifm[elem_lo(c, WORD_WIDTH) +: WORD_WIDTH];
        n++;
      end
    end
    packed_cnt = CNT_WIDTH'(n);
  end
  assign red_sum = {1'b0, stat_red} + 33'($countones(s1_rmask));
  assign miss_sum = {1'b0, stat_miss} + 33'($countones(s1_miss));
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid <= 1'b0;
      prev_ch <= '0;
      prev_ky <= '0;
      prev_kx <= '0;
      prev_lifm <= '0;
      s1_full <= 1'b0;
      s1_lifm <= '0;
      s1_rmask <= '0;
      s1_miss <= '0;
      s1_dr <= '0;
      out_valid <= 1'b0;
      out_lifm <= '0;
      out_cnt <= '0;
      out_rmask <= '0;
      out_dr <= '0;
      stat_red <= '0;
      stat_miss <= '0;
    end else begin
      if (accept) begin
        hist_valid <= 1'b1;
        prev_ch <= in_ch;
        prev_ky <= in_ky;
        prev_kx <= in_kx;
        prev_lifm <= in_lifm;
        s1_lifm <= in_lifm;
        s1_rmask <= red;
        s1_miss <= miss;
        s1_dr <= cfg_mode == MODE_BYPASS ? '0 : geo_dr;
      end
      if (s1_adv) s1_full <= in_valid;
      if (s2_adv) out_valid <= s1_full;
      if (s2_adv && s1_full) begin
        out_lifm <= packed_lifm;
        out_cnt <= packed_cnt;
        out_rmask <= s1_rmask;
        out_dr <= s1_dr;
      end
      if (stat_clr) begin
        stat_red <= '0;
        stat_miss <= '0;
      end else if (s1_full && s2_adv) begin
        stat_red <= red_sum[32] ? '1 : red_sum[31:0];
        stat_miss <= miss_sum[32] ? '1 : miss_sum[31:0];
      end
    end
  end
endmodule

// File: tb/tb_redundancy_compactor.sv
// tb_redundancy_compactor: scoreboard bench, reference model predicts each beat at accept.
module tb_redundancy_compactor;
  logic clk = 0, reset = 1, stat_clr = 0, in_valid = 0, in_first = 0, out_ready = 1, busy = 0;
  logic [2:0] cfg_st_log2 = 0;
  logic [1:0] cfg_mode = 1;
  logic [7:0] in_ch = 0;
  logic [3:0] in_ky = 0, in_kx = 0;
  logic [63:0] in_lifm = 0;
  logic in_ready, out_valid;
  logic [63:0] out_lifm;
  logic [3:0] out_cnt;
  logic [7:0] out_rmask;
  logic [6:0] out_dr;
  logic [31:0] stat_red, stat_miss;
  typedef struct {
    logic [63:0] lifm;
    logic [3:0] cnt;
    logic [7:0] rmask;
    logic [6:0] dr;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  logic m_hv = 0;
  logic [7:0] m_ch = 0;
  logic [3:0] m_ky = 0, m_kx = 0;
  logic [63:0] m_lifm = 0;
  longint m_red = 0, m_miss = 0;

  redundancy_compactor dut (
    .clk(clk), .reset(reset), .cfg_st_log2(cfg_st_log2), .cfg_mode(cfg_mode), .stat_clr(stat_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_ch(in_ch), .in_ky(in_ky),
    .in_kx(in_kx), .in_lifm(in_lifm), .out_valid(out_valid), .out_ready(out_ready), .out_lifm(out_lifm),
    .out_cnt(out_cnt), .out_rmask(out_rmask), .out_dr(out_dr), .stat_red(stat_red), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int base);
    logic [63:0] l;
    for (int c = 0; c < 8; c++) l[c*8 +: 8] = 8'(base + 7 - c);
    return l;
  endfunction

  function automatic void model();
    exp_t e;
    int d, st, dr, n;
    logic geo;
    d = int'(in_kx) - int'(m_kx);
    st = 1 << cfg_st_log2;
    geo = m_hv && !in_first && in_ch == m_ch && in_ky == m_ky && d > 0 && d % st == 0 && d / st < 8;
    dr = (geo && cfg_mode != 0) ? d / st : 0;
    e.lifm = 0;
    e.rmask = 0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (cfg_mode != 0 && geo && c >= dr) begin
        if (cfg_mode == 1 || in_lifm[c*8 +: 8] == m_lifm[(c-dr)*8 +: 8]) e.rmask[c] = 1;
        else m_miss++;
      end
      if (!e.rmask[c]) begin
        e.lifm[n*8 +: 8] = in_lifm[c*8 +: 8];
        n++;
      end
    end
    e.cnt = 4'(n);
    e.dr = 7'(dr);
    m_red += 8 - n;
    sb.push_back(e);
    m_hv = 1;
    m_ch = in_ch;
    m_ky = in_ky;
    m_kx = in_kx;
    m_lifm = in_lifm;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, (sb.size() == 2 && !out_ready) ? 0 : 1);
      if (out_valid) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          chk("out_lifm", out_lifm, sb[0].lifm);
          chk("out_cnt", out_cnt, sb[0].cnt);
          chk("out_rmask", out_rmask, sb[0].rmask);
          chk("out_dr", out_dr, sb[0].dr);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) model();
    end
  end

  task automatic send(input logic first, input logic [7:0] ch, input logic [3:0] ky, kx, input logic [63:0] lifm);
    logic done;
    done = 0;
    in_valid = 1;
    in_first = first;
    in_ch = ch;
    in_ky = ky;
    in_kx = kx;
    in_lifm = lifm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", in_ready, 1);
  endtask

  task automatic idle();
    in_valid = 0;
    in_first = 0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1;
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_stats();
    chk("stat_red", stat_red, m_red);
    chk("stat_miss", stat_miss, m_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] l;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_lifm", out_lifm, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_stat_red", stat_red, 0);
    reset = 0;
    // geometry-only reuse, with latency check on the first beat
    send(1, 0, 0, 0, mk(0));
    idle();
    chk("lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_out", out_valid, 1);
    send(0, 0, 0, 1, mk(1));
    drain();
    chk_stats();
    // value check with one corrupted element
    stat_clr = 1;
    @(posedge clk);
    #1;
    stat_clr = 0;
    m_red = 0;
    m_miss = 0;
    chk_stats();
    cfg_mode = 2;
    send(1, 0, 0, 0, mk(0));
    l = mk(1);
    l[31:24] = 8'hAA;
    send(0, 0, 0, 1, l);
    drain();
    chk_stats();
    // stride 2: odd step, even step, ky change, in_first, channel change
    cfg_mode = 1;
    cfg_st_log2 = 1;
    send(1, 0, 0, 0, mk(0));
    send(0, 0, 0, 1, mk(0));
    send(0, 0, 0, 3, mk(1));
    send(0, 0, 1, 5, mk(2));
    send(1, 0, 1, 7, mk(3));
    send(0, 1, 1, 9, mk(4));
    drain();
    chk_stats();
    // backpressure with out_ready toggling
    cfg_mode = 2;
    cfg_st_log2 = 0;
    busy = 1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i == 0, 0, 0, 4'(i), mk(i));
        idle();
        busy = 0;
      end
      while (busy) begin
        @(posedge clk);
        #1;
        out_ready = ~out_ready;
      end
    join
    drain();
    chk_stats();
    // bypass, then distance out of range and negative step
    cfg_mode = 0;
    send(1, 0, 0, 0, mk(0));
    send(0, 0, 0, 1, mk(1));
    drain();
    cfg_mode = 1;
    send(1, 0, 0, 0, mk(0));
    send(0, 0, 0, 9, mk(1));
    send(0, 0, 0, 2, mk(1));
    drain();
    chk_stats();
    // random traffic, value-check mode
    cfg_mode = 2;
    busy = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          for (int c = 0; c < 8; c++) l[c*8 +: 8] = 8'($urandom_range(0, 2));
          send($urandom_range(0, 9) == 0, 8'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)), l);
        end
        idle();
        busy = 0;
      end
      while (busy) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    drain();
    chk_stats();
    // reset with both stages full
    cfg_mode = 1;
    out_ready = 0;
    send(1, 0, 0, 0, mk(0));
    send(0, 0, 0, 1, mk(1));
    idle();
    chk("both_full_ready", in_ready, 0);
    reset = 1;
    sb.delete();
    m_hv = 0;
    m_red = 0;
    m_miss = 0;
    @(posedge clk);
    #1;
    reset = 0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk_stats();
    out_ready = 1;
    send(0, 0, 0, 2, mk(2));
    drain();
    chk_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
